// File: rtl/pixel_scan_ctrl.sv
// Frame scan sequencer: raster-walks pixels into the ray pipeline, pairs returning hits with
// a latency-matched valid shift register and emits one framebuffer write per pixel.
// Optional hit counter output enabled by defining PIXEL_SCAN_STATS_EN.
module pixel_scan_ctrl #(
  parameter int unsigned H_RES    = 800,
  parameter int unsigned V_RES    = 600,
  parameter int unsigned PIPE_LAT = 12,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic [9:0]        pixel_x,
  output logic [9:0]        pixel_y,
  output logic              pixel_valid,
  input  logic              hit_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              busy,
`ifdef PIXEL_SCAN_STATS_EN
  output logic [ADDR_W-1:0] hit_count,
`endif
  output logic              frame_done
);

  localparam int unsigned XY_W = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PIPE_LAT-1:0] vld_sr_q;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [XY_W-1:0]     x_d, y_d;
  logic [ADDR_W-1:0]   wr_addr_d;
  logic                valid_d, wr_en_d, wr_data_d, busy_d, done_d;
  logic                tail, wr_fire, last_pix, line_end;

  assign tail     = vld_sr_q[PIPE_LAT-1];
  assign wr_fire  = tail & ~stall;
  assign line_end = (pixel_x == XY_W'(H_RES - 1));
  assign last_pix = line_end && (pixel_y == XY_W'(V_RES - 1));

  // Next-state, scan counters and writeback
  always_comb begin
    state_d   = state_q;
    x_d       = pixel_x;
    y_d       = pixel_y;
    valid_d   = pixel_valid;
    wr_cnt_d  = wr_cnt_q;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    wr_en_d   = wr_fire;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d  = S_SCAN;
          x_d      = '0;
          y_d      = '0;
          valid_d  = 1'b1;
          wr_cnt_d = '0;
        end
      end
      S_SCAN: begin
        if (!stall) begin
          if (last_pix) begin
            valid_d = 1'b0;
            state_d = S_DRAIN;
          end else if (line_end) begin
            x_d = '0;
            y_d = pixel_y + XY_W'(1);
          end else begin
            x_d = pixel_x + XY_W'(1);
          end
        end
      end
      S_DRAIN: begin
        // Shift register empties in the same cycle the final write is presented
        if (!stall && (vld_sr_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_fire) begin
      wr_addr_d = wr_cnt_q;
      wr_data_d = hit_in;
      wr_cnt_d  = wr_cnt_q + ADDR_W'(1);
    end

    busy_d = (state_d == S_SCAN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      vld_sr_q    <= '0;
      wr_cnt_q    <= '0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      pixel_valid <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      pixel_x     <= x_d;
      pixel_y     <= y_d;
      pixel_valid <= valid_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      busy        <= busy_d;
      frame_done  <= done_d;
      // Valid tracker freezes together with the downstream pipeline
      if (!stall) begin
        vld_sr_q[0] <= pixel_valid;
        for (int i = 1; i < int'(PIPE_LAT); i++) vld_sr_q[i] <= vld_sr_q[i-1];
      end
    end
  end

`ifdef PIXEL_SCAN_STATS_EN
  always_ff @(posedge sysclk) begin
    if (rst) begin
      hit_count <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      hit_count <= '0;
    end else if (wr_fire && hit_in) begin
      hit_count <= hit_count + ADDR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pixel_scan_ctrl.sv
// Directed bench for pixel_scan_ctrl: small 4x3 frame instance plus a larger 40x30 instance.
module tb_pixel_scan_ctrl;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned L  = 5;
  localparam int unsigned AW = 19;
  localparam int unsigned H2 = 40;
  localparam int unsigned V2 = 30;
  localparam int unsigned L2 = 12;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic          rst, start, stall, hit_in;
  logic [9:0]    pixel_x, pixel_y;
  logic          pixel_valid, wr_en, wr_data, busy, frame_done;
  logic [AW-1:0] wr_addr;

  logic          start2, stall2, hit2;
  logic [9:0]    px2, py2;
  logic          pv2, we2, wd2, busy2, fd2;
  logic [AW-1:0] wa2;

`ifdef PIXEL_SCAN_STATS_EN
  logic [AW-1:0] hit_count, hc2;
`endif

  pixel_scan_ctrl #(.H_RES(H), .V_RES(V), .PIPE_LAT(L), .ADDR_W(AW)) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .stall(stall),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid),
    .hit_in(hit_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy),
`ifdef PIXEL_SCAN_STATS_EN
    .hit_count(hit_count),
`endif
    .frame_done(frame_done)
  );

  pixel_scan_ctrl #(.H_RES(H2), .V_RES(V2), .PIPE_LAT(L2), .ADDR_W(AW)) dut2 (
    .sysclk(sysclk), .rst(rst), .start(start2), .stall(stall2),
    .pixel_x(px2), .pixel_y(py2), .pixel_valid(pv2),
    .hit_in(hit2), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2),
    .busy(busy2),
`ifdef PIXEL_SCAN_STATS_EN
    .hit_count(hc2),
`endif
    .frame_done(fd2)
  );

  int checks = 0;
  int errors = 0;

  // Per-frame observations gathered by run_frame
  int n_wr, bad_addr, bad_data, first_wr, done_cyc, busy_bad, first_valid;
  bit wrap_seen;

  // Starts a frame (start sampled at cycle 0) and returns in the frame_done cycle or after max_cyc.
  // hit_in models the pipeline: result for address a is (a odd).
  task automatic run_frame(input int st_lo, input int st_hi, input int st_one,
                           input int start_again, input int max_cyc);
    logic [9:0] px_prev, py_prev;
    bit pv_prev;
    n_wr = 0; bad_addr = 0; bad_data = 0; busy_bad = 0;
    first_wr = -1; done_cyc = -1; first_valid = -1; wrap_seen = 0;
    pv_prev = 0; px_prev = '0; py_prev = '0;
    start = 1'b0; stall = 1'b0; hit_in = 1'b0;
    @(posedge sysclk); #1;
    start = 1'b1;
    @(posedge sysclk); #1;
    start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (pixel_valid && first_valid < 0) first_valid = c;
      if (pixel_valid && pv_prev && px_prev == 10'd3 && py_prev == 10'd0 &&
          pixel_x == 10'd0 && pixel_y == 10'd1) wrap_seen = 1;
      pv_prev = pixel_valid; px_prev = pixel_x; py_prev = pixel_y;
      if (wr_en) begin
        if (first_wr < 0) first_wr = c;
        if (wr_addr !== AW'(n_wr)) bad_addr++;
        if (wr_data !== 1'(n_wr % 2)) bad_data++;
        n_wr++;
      end
      if (frame_done) begin
        done_cyc = c;
        if (busy !== 1'b0) busy_bad++;
        stall = 1'b0;
        start = 1'b0;
        return;
      end
      if (busy !== 1'b1) busy_bad++;
      hit_in = 1'(n_wr % 2);
      stall  = (c >= st_lo && c <= st_hi) || (c == st_one);
      start  = (c == start_again);
      @(posedge sysclk); #1;
    end
    stall = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stall = 1'b0; hit_in = 1'b0;
    start2 = 1'b0; stall2 = 1'b0; hit2 = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    checks++;
    if ({pixel_x, pixel_y, pixel_valid, wr_en, wr_addr, wr_data, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: x=%0d y=%0d v=%b we=%b addr=%0d d=%b busy=%b done=%b, required all 0",
               pixel_x, pixel_y, pixel_valid, wr_en, wr_addr, wr_data, busy, frame_done);
    end
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    run_frame(-1, -1, -1, -1, 60);
    checks++; if (n_wr != 12) begin errors++; $display("FAIL full_writes: got %0d required 12", n_wr); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL full_addr_order: %0d bad, required 0", bad_addr); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL full_data_pattern: %0d bad, required 0", bad_data); end
    checks++; if (first_valid != 1) begin errors++; $display("FAIL full_first_valid: cycle %0d required 1", first_valid); end
    checks++; if (first_wr != 7) begin errors++; $display("FAIL full_first_wr: cycle %0d required 7", first_wr); end
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL full_done_cycle: cycle %0d required 19", done_cyc); end
    checks++; if (!wrap_seen) begin errors++; $display("FAIL full_raster_wrap: seen %0d required 1", wrap_seen); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL full_busy: %0d bad cycles, required 0", busy_bad); end
  endtask

  task automatic test_stall();
    run_frame(4, 6, 12, -1, 60);
    checks++; if (n_wr != 12) begin errors++; $display("FAIL stall_writes: got %0d required 12", n_wr); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL stall_addr_order: %0d bad, required 0", bad_addr); end
    checks++; if (bad_data != 0) begin errors++; $display("FAIL stall_data: %0d bad, required 0", bad_data); end
    checks++; if (first_wr != 10) begin errors++; $display("FAIL stall_first_wr: cycle %0d required 10", first_wr); end
    checks++; if (done_cyc != 23) begin errors++; $display("FAIL stall_done_cycle: cycle %0d required 23", done_cyc); end
  endtask

  task automatic test_start_ignored();
    int act;
    run_frame(-1, -1, -1, 5, 60);
    checks++; if (n_wr != 12) begin errors++; $display("FAIL restart_writes: got %0d required 12", n_wr); end
    checks++; if (done_cyc != 19) begin errors++; $display("FAIL restart_done_cycle: cycle %0d required 19", done_cyc); end
    checks++; if (bad_addr != 0) begin errors++; $display("FAIL restart_addr: %0d bad, required 0", bad_addr); end
    start = 1'b1;
    @(posedge sysclk); #1;
    start = 1'b0;
    act = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy || pixel_valid || wr_en) act++;
      @(posedge sysclk); #1;
    end
    checks++; if (act != 0) begin errors++; $display("FAIL start_in_done: %0d active cycles, required 0", act); end
  endtask

  task automatic test_mid_reset();
    int stray;
    run_frame(-1, -1, -1, -1, 7);
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== AW'(1)) begin
      errors++; $display("FAIL pre_reset_write: we=%b addr=%0d required we=1 addr=1", wr_en, wr_addr);
    end
    rst = 1'b1;
    @(posedge sysclk); #1;
    rst = 1'b0;
    checks++;
    if ({pixel_x, pixel_y, pixel_valid, wr_en, wr_addr, wr_data, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: x=%0d y=%0d v=%b we=%b addr=%0d d=%b busy=%b done=%b, required all 0",
               pixel_x, pixel_y, pixel_valid, wr_en, wr_addr, wr_data, busy, frame_done);
    end
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      if (wr_en || busy || frame_done) stray++;
      @(posedge sysclk); #1;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL post_reset_quiet: %0d active cycles, required 0", stray); end
    run_frame(-1, -1, -1, -1, 60);
    checks++; if (n_wr != 12 || bad_addr != 0) begin
      errors++; $display("FAIL clean_frame: writes=%0d bad_addr=%0d required 12/0", n_wr, bad_addr);
    end
    checks++; if (first_wr != 7 || done_cyc != 19) begin
      errors++; $display("FAIL clean_frame_timing: first_wr=%0d done=%0d required 7/19", first_wr, done_cyc);
    end
  endtask

  task automatic test_stats();
`ifdef PIXEL_SCAN_STATS_EN
    run_frame(-1, -1, -1, -1, 60);
    checks++; if (hit_count !== AW'(6)) begin errors++; $display("FAIL stats_count: got %0d required 6", hit_count); end
    @(posedge sysclk); #1;
    checks++; if (hit_count !== AW'(6)) begin errors++; $display("FAIL stats_hold: got %0d required 6", hit_count); end
    start = 1'b1;
    @(posedge sysclk); #1;
    start = 1'b0;
    checks++; if (hit_count !== AW'(0)) begin errors++; $display("FAIL stats_clear: got %0d required 0", hit_count); end
    rst = 1'b1;
    @(posedge sysclk); #1;
    rst = 1'b0;
`endif
  endtask

  task automatic test_large_frame();
    int n, bad_d, done_c, first_c, last_a, max_x, max_y;
    n = 0; bad_d = 0; done_c = -1; first_c = -1; last_a = -1; max_x = 0; max_y = 0;
    start2 = 1'b1;
    @(posedge sysclk); #1;
    start2 = 1'b0;
    for (int c = 1; c <= 3000; c++) begin
      if (pv2) begin
        if (int'(px2) > max_x) max_x = int'(px2);
        if (int'(py2) > max_y) max_y = int'(py2);
      end
      if (we2) begin
        if (first_c < 0) first_c = c;
        if (wd2 !== 1'b0) bad_d++;
        last_a = int'(wa2);
        n++;
      end
      if (fd2) begin done_c = c; break; end
      @(posedge sysclk); #1;
    end
    checks++; if (n != 1200) begin errors++; $display("FAIL large_writes: got %0d required 1200", n); end
    checks++; if (last_a != 1199) begin errors++; $display("FAIL large_last_addr: got %0d required 1199", last_a); end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL large_data: %0d nonzero, required 0", bad_d); end
    checks++; if (first_c != 14) begin errors++; $display("FAIL large_first_wr: cycle %0d required 14", first_c); end
    checks++; if (done_c != 1214) begin errors++; $display("FAIL large_done_cycle: cycle %0d required 1214", done_c); end
    checks++; if (max_x != 39 || max_y != 29) begin
      errors++; $display("FAIL large_extent: max x=%0d y=%0d required 39/29", max_x, max_y);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_start_ignored();
    test_mid_reset();
    test_stats();
    test_large_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
